multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Sequencing controller for the multi-cycle version of the processor datapath, which has one shared instruction/data memory, IR, A/B/ALUOut/MDR holding registers and the CPSR.
- Steps each instruction through fetch, decode, execute, memory and writeback states.
- Handles the memory ready handshake and timeout, and evaluates the bvf/ben CPSR branch conditions.
- Counts retired instructions and halts on an illegal opcode or a memory timeout.

Parameters:
- MEM_TIMEOUT, 16, maximum number of cycles waiting for mem_ready before entering ERROR; counter width is 8 bits, legal range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous active-high reset
- opcode  in  6  IR[31:26]; sampled in DECODE
- svz  in  3  CPSR flags {S,V,Z}
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- iord  out  1  0 = PC address, 1 = ALUOut address
- mem_read  out  1  read strobe
- mem_write  out  1  write strobe
- ir_write  out  1  load IR
- pc_write  out  1  unconditional PC load
- pc_write_cond  out  1  PC load if ALU zero (beq)
- pc_source  out  2  00 ALU result, 01 ALUOut, 10 jump target {PC[31:28],IR[25:0],2'b00}
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct field
- reg_dst  out  1  1 = rd, 0 = rt
- mem_to_reg  out  1  1 = MDR
- reg_write  out  1  register file write
- cpsr_write  out  1  CPSR update enable
- halt  out  1  sticky error indication
- instr_count  out  32  retired-instruction counter

Behaviour:
- Opcodes:
  - R-type 6'h00
  - lw 6'h23
  - sw 6'h2B
  - beq 6'h04
  - j 6'h02
  - bvf 6'h14
  - ben 6'h15
  - any other value is illegal.
- Reset:
  - rst is sampled on the rising edge of clk.
  - Next state is FETCH; wait counter and instr_count clear to 0; halt clears to 0.
  - While rst is high, all outputs are forced to 0.
- Output style:
  - All outputs are Moore (decoded from state), except ir_write, pc_write in FETCH, and the state exit in memory states, which are qualified by mem_ready in the same cycle.
  - Unlisted outputs are 0 in every state.
- FETCH:
  - mem_req=1, mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - On mem_ready: ir_write=1, pc_write=1, next state DECODE.
- DECODE:
  - alu_src_a=0, alu_src_b=11, alu_op=00, which computes the branch target into ALUOut.
  - Next state by opcode: R-type -> R_EXEC; lw/sw -> MEM_ADDR; beq -> BEQ; j -> JUMP; bvf/ben -> CBR; illegal -> ERROR.
- R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=10, cpsr_write=1; next state R_WB.
- R_WB: reg_dst=1, mem_to_reg=0, reg_write=1; retire; next state FETCH.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=00; next state MEM_RD for lw, MEM_WR for sw.
- MEM_RD: mem_req=1, mem_read=1, iord=1; on mem_ready, next state MEM_WB.
- MEM_WB: reg_dst=0, mem_to_reg=1, reg_write=1; retire; next state FETCH.
- MEM_WR: mem_req=1, mem_write=1, iord=1; on mem_ready, retire and next state FETCH.
- BEQ: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01; retire; next state FETCH.
- JUMP: pc_write=1, pc_source=10; retire; next state FETCH.
- CBR: pc_source=01; pc_write=1 if the branch is taken, else 0; retire; next state FETCH.
  - bvf is taken if V (svz[1]).
  - ben is taken if S|Z (svz[2]|svz[0]).
  - The opcode is held from DECODE in an internal 1-bit register, because IR does not change.
  - svz is sampled in the CBR cycle.
- Wait timeout:
  - The wait counter increments each cycle spent in FETCH, MEM_RD or MEM_WR without mem_ready, and clears on any state change.
  - If the counter reaches MEM_TIMEOUT while mem_ready=0, next state is ERROR.
  - mem_ready arriving in the same cycle as the limit is reached wins: the access completes.
- ERROR: halt=1 and all strobes 0; the state is held until rst.
- Retire: instr_count increments by 1 on the retiring cycle and wraps from 0xFFFFFFFF to 0. Illegal opcodes and timeouts do not retire.
- Latency with zero wait states:
  - R-type 4 cycles
  - lw 5 cycles
  - sw 4 cycles
  - beq, j, bvf, ben 3 cycles each
- Reset mid-instruction: returns to FETCH on the next edge, with no write strobes asserted during the reset cycle.

Test Plan:
- Reset, mem_ready tied to 1, R-type then lw then sw -> state sequence FETCH,DECODE,R_EXEC,R_WB, then FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB, then FETCH,DECODE,MEM_ADDR,MEM_WR; instr_count=3 after 13 cycles; cpsr_write high exactly once.
- bvf with svz=3'b010 -> pc_write=1 and pc_source=01 in CBR. bvf with svz=3'b101 -> pc_write=0. ben with svz=3'b001 -> pc_write=1. ben with svz=3'b010 -> pc_write=0.
- j -> JUMP cycle has pc_write=1, pc_source=10; beq -> pc_write_cond=1, alu_op=01, pc_write=0.
- FETCH with mem_ready low 3 cycles, then high -> ir_write pulses once, on the 4th cycle; no ERROR. With MEM_TIMEOUT=4 and mem_ready never asserted -> halt=1 and held; instr_count unchanged.
- Opcode 6'h3F -> DECODE goes to ERROR; halt=1; pulsing rst clears halt and restarts in FETCH with instr_count=0.
- rst asserted during MEM_WR while mem_ready=1 -> mem_write=0 in that cycle; next state FETCH; instr_count=0.

Source files
------------

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multi-cycle datapath: fetch/decode/execute/memory/writeback,
// memory ready handshake with timeout, CPSR branch evaluation and retire counting.
module multicycle_control #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic [2:0]  svz,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        iord,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic [1:0]  pc_source,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        cpsr_write,
  output logic        halt,
  output logic [31:0] instr_count
);

  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_BVF = 6'h14;
  localparam logic [5:0] OP_BEN = 6'h15;
  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [3:0] {
    FETCH, DECODE, R_EXEC, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR,
    BEQ, JUMP, CBR, ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  wait_q, wait_d;
  logic [31:0] count_q;
  // One bit serves both decisions: sw (vs lw) in MEM_ADDR, ben (vs bvf) in CBR.
  logic        sel_q, sel_d;
  logic        retire, wait_inc, timed_out;

  assign timed_out = (wait_q == WAIT_LAST);

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    retire        = 1'b0;
    wait_inc      = 1'b0;
    mem_req       = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    cpsr_write    = 1'b0;
    halt          = 1'b0;
    case (state_q)
      FETCH: begin
        mem_req   = 1'b1;
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = DECODE;
        end else if (timed_out) state_d = ERROR;
        else wait_inc = 1'b1;
      end
      DECODE: begin
        alu_src_b = 2'b11;
        sel_d     = (opcode == OP_SW) || (opcode == OP_BEN);
        case (opcode)
          OP_R:          state_d = R_EXEC;
          OP_LW, OP_SW:  state_d = MEM_ADDR;
          OP_BEQ:        state_d = BEQ;
          OP_J:          state_d = JUMP;
          OP_BVF, OP_BEN: state_d = CBR;
          default:       state_d = ERROR;
        endcase
      end
      R_EXEC: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'b10;
        cpsr_write = 1'b1;
        state_d    = R_WB;
      end
      R_WB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = sel_q ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_req  = 1'b1;
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) state_d = MEM_WB;
        else if (timed_out) state_d = ERROR;
        else wait_inc = 1'b1;
      end
      MEM_WB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_d    = FETCH;
      end
      MEM_WR: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = FETCH;
        end else if (timed_out) state_d = ERROR;
        else wait_inc = 1'b1;
      end
      BEQ: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
        retire    = 1'b1;
        state_d   = FETCH;
      end
      CBR: begin
        pc_source = 2'b01;
        pc_write  = sel_q ? (svz[2] | svz[0]) : svz[1];
        retire    = 1'b1;
        state_d   = FETCH;
      end
      ERROR: halt = 1'b1;
      default: state_d = ERROR;
    endcase

    if (state_d != state_q) wait_d = 8'd0;
    else if (wait_inc)      wait_d = wait_q + 8'd1;
    else                    wait_d = wait_q;

    // Reset cycle must never leak a strobe, even mid-access.
    if (rst) begin
      mem_req       = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      pc_source     = 2'b00;
      alu_src_a     = 1'b0;
      alu_src_b     = 2'b00;
      alu_op        = 2'b00;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      reg_write     = 1'b0;
      cpsr_write    = 1'b0;
      halt          = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      wait_q  <= 8'd0;
      count_q <= 32'd0;
      sel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      sel_q   <= sel_d;
      if (retire) count_q <= count_q + 32'd1;
    end
  end

  assign instr_count = rst ? 32'd0 : count_q;

endmodule
